// File: rtl/scan_pkg.sv
// Shared types and chain field layout for the scan-chain master.
// The chain word is {ready, rdata, wdata, addr, ren, wen}, LSB shifted first.
package scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_IN,
        ST_LOAD_CHIP,
        ST_ID_WAIT,
        ST_SETTLE,
        ST_LOAD_CHAIN,
        ST_SHIFT_OUT,
        ST_RESP
    } scan_state_t;

    function automatic int chain_len(input int addr_w, input int data_w);
        return 2 + addr_w + 2 * data_w + 1;
    endfunction

    function automatic int wen_bit();
        return 0;
    endfunction

    function automatic int ren_bit();
        return 1;
    endfunction

    function automatic int addr_lsb();
        return 2;
    endfunction

    function automatic int wdata_lsb(input int addr_w);
        return 2 + addr_w;
    endfunction

    function automatic int rdata_lsb(input int addr_w, input int data_w);
        return 2 + addr_w + data_w;
    endfunction

    function automatic int ready_bit(input int addr_w, input int data_w);
        return 2 + addr_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/scan_phase_gen.sv
// Step timer: one tick per PHASE_CYC cycles plus a 2-bit step index.
// Held at zero while disabled, so every enable rise (or clr) restarts at step 0.
module scan_phase_gen #(
    parameter int PHASE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic       tick,
    output logic [1:0] step
);

    localparam int CNT_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_W'(PHASE_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            step <= 2'd0;
        end else if (!en || clr) begin
            cnt  <= '0;
            step <= 2'd0;
        end else if (tick) begin
            cnt  <= '0;
            step <= step + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scan_chain_master.sv
// Turns valid/ready register requests into the two-phase scan protocol:
// shift in, load_chip, scan_id toggle, and for reads capture + shift out.
module scan_chain_master
    import scan_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 32,
    parameter int PHASE_CYC   = 4,
    parameter int ID_WAIT_CYC = 5,
    parameter int SETTLE_CYC  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ack,
    output logic              rsp_is_read,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_chip_ready,
    output logic              rsp_addr_ok,
    output logic              scan_phi,
    output logic              scan_phi_bar,
    output logic              scan_data_in,
    output logic              scan_load_chip,
    output logic              scan_load_chain,
    input  logic              scan_data_out,
    output logic              scan_id
);

    localparam int CHAIN_LEN = chain_len(ADDR_W, DATA_W);
    localparam int WEN_BIT   = wen_bit();
    localparam int REN_BIT   = ren_bit();
    localparam int ADDR_LSB  = addr_lsb();
    localparam int WDATA_LSB = wdata_lsb(ADDR_W);
    localparam int RDATA_LSB = rdata_lsb(ADDR_W, DATA_W);
    localparam int READY_BIT = ready_bit(ADDR_W, DATA_W);
    localparam int ID_N      = (ID_WAIT_CYC < 1) ? 1 : ID_WAIT_CYC;
    localparam int SETTLE_N  = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    localparam int WAIT_MAX  = (ID_N > SETTLE_N) ? ID_N : SETTLE_N;
    localparam int WAIT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam int BIT_W     = $clog2(CHAIN_LEN);

    scan_state_t          state;
    logic [CHAIN_LEN-1:0] word;
    logic [CHAIN_LEN-1:0] capture;
    logic [CHAIN_LEN-1:0] req_word;
    logic [BIT_W-1:0]     bit_cnt;
    logic [3:0]           lc_step;
    logic [WAIT_W-1:0]    wait_cnt;
    logic                 is_write;
    logic [ADDR_W-1:0]    addr_q;
    logic                 tick;
    logic [1:0]           step;
    logic                 phase_en;
    logic                 phase_clr;
    logic                 unused_capture;

    assign req_ready = (state == ST_IDLE) && !rsp_valid;
    assign phase_en  = (state == ST_SHIFT_IN) || (state == ST_LOAD_CHIP) ||
                       (state == ST_LOAD_CHAIN) || (state == ST_SHIFT_OUT);
    // SHIFT_OUT follows LOAD_CHAIN with the timer still running, so force step 0.
    assign phase_clr = (state == ST_LOAD_CHAIN) && tick && (lc_step == 4'd9);
    assign unused_capture = ^{capture[REN_BIT], capture[WEN_BIT], capture[WDATA_LSB +: DATA_W]};

    always_comb begin
        req_word = '0;
        req_word[WEN_BIT] = req_write;
        req_word[REN_BIT] = !req_write;
        req_word[ADDR_LSB +: ADDR_W] = req_addr;
        if (req_write) req_word[WDATA_LSB +: DATA_W] = req_wdata;
    end

    scan_phase_gen #(.PHASE_CYC(PHASE_CYC)) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (phase_en),
        .clr   (phase_clr),
        .tick  (tick),
        .step  (step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            word            <= '0;
            capture         <= '0;
            bit_cnt         <= '0;
            lc_step         <= 4'd0;
            wait_cnt        <= '0;
            is_write        <= 1'b0;
            addr_q          <= '0;
            scan_phi        <= 1'b0;
            scan_phi_bar    <= 1'b0;
            scan_data_in    <= 1'b0;
            scan_load_chip  <= 1'b0;
            scan_load_chain <= 1'b0;
            scan_id         <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_is_read     <= 1'b0;
            rsp_rdata       <= '0;
            rsp_chip_ready  <= 1'b0;
            rsp_addr_ok     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        state        <= ST_SHIFT_IN;
                        is_write     <= req_write;
                        addr_q       <= req_addr;
                        word         <= req_word;
                        bit_cnt      <= '0;
                        scan_phi     <= 1'b1;
                        scan_data_in <= req_word[0];
                        capture      <= {scan_data_out, capture[CHAIN_LEN-1:1]};
                    end
                end
                ST_SHIFT_IN, ST_SHIFT_OUT: begin
                    if (tick) begin
                        case (step)
                            2'd0: scan_phi <= 1'b0;
                            2'd1: scan_phi_bar <= 1'b1;
                            2'd2: scan_phi_bar <= 1'b0;
                            default: begin
                                word <= word >> 1;
                                if (bit_cnt == BIT_W'(CHAIN_LEN - 1)) begin
                                    scan_data_in <= 1'b0;
                                    if (state == ST_SHIFT_IN) begin
                                        state          <= ST_LOAD_CHIP;
                                        scan_load_chip <= 1'b1;
                                    end else begin
                                        state <= ST_RESP;
                                    end
                                end else begin
                                    bit_cnt      <= bit_cnt + BIT_W'(1);
                                    scan_phi     <= 1'b1;
                                    scan_data_in <= word[1];
                                    capture      <= {scan_data_out, capture[CHAIN_LEN-1:1]};
                                end
                            end
                        endcase
                    end
                end
                ST_LOAD_CHIP: begin
                    if (tick) begin
                        if (step == 2'd0) scan_load_chip <= 1'b0;
                        if (step == 2'd3) begin
                            state    <= ST_ID_WAIT;
                            wait_cnt <= '0;
                        end
                    end
                end
                ST_ID_WAIT: begin
                    if (wait_cnt == WAIT_W'(ID_N - 1)) begin
                        scan_id  <= !scan_id;
                        wait_cnt <= '0;
                        state    <= is_write ? ST_RESP : ST_SETTLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (wait_cnt == WAIT_W'(SETTLE_N - 1)) begin
                        state           <= ST_LOAD_CHAIN;
                        scan_load_chain <= 1'b1;
                        lc_step         <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_LOAD_CHAIN: begin
                    // Ten steps: capture window (strobe + phi + phi_bar) then five quiet steps.
                    if (tick) begin
                        lc_step <= lc_step + 4'd1;
                        case (lc_step)
                            4'd0: scan_phi <= 1'b1;
                            4'd1: scan_phi <= 1'b0;
                            4'd2: scan_phi_bar <= 1'b1;
                            4'd3: scan_phi_bar <= 1'b0;
                            4'd4: scan_load_chain <= 1'b0;
                            4'd9: begin
                                state        <= ST_SHIFT_OUT;
                                bit_cnt      <= '0;
                                scan_phi     <= 1'b1;
                                scan_data_in <= 1'b0;
                                capture      <= {scan_data_out, capture[CHAIN_LEN-1:1]};
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid      <= 1'b1;
                        rsp_is_read    <= !is_write;
                        rsp_rdata      <= is_write ? '0 : capture[RDATA_LSB +: DATA_W];
                        rsp_chip_ready <= !is_write && capture[READY_BIT];
                        rsp_addr_ok    <= is_write || (capture[ADDR_LSB +: ADDR_W] == addr_q);
                    end else if (rsp_ack) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/scan_chain_master.md
Name: scan_chain_master

Overview:
- Synthesizable, parametrised scan-chain master.
- Converts a valid/ready register-access request into the full scan protocol. For writes: shift in, pulse scan_load_chip, toggle scan_id. Reads add: settle, scan_load_chain capture, shift out.
- Sits between an on-chip/FPGA host bus and the chip scan pins.
- Generalises width and timing, and adds readback checking, none of which the fixed behavioural driver had.

Parameters:
- ADDR_W, 20, address field width.
- DATA_W, 32, wdata and rdata field width.
- PHASE_CYC, 4, clk cycles per scan phase step (min 1).
- ID_WAIT_CYC, 5, clk cycles from end of load_chip sequence to scan_id toggle.
- SETTLE_CYC, 20, clk cycles from scan_id toggle to load_chain start (reads only).
- CHAIN_LEN (localparam), 2+ADDR_W+2*DATA_W+1 (=87 at defaults).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response valid, held until rsp_ack
- rsp_ack  in  1  response consumed
- rsp_is_read  out  1  response belongs to a read
- rsp_rdata  out  DATA_W  captured rdata field (0 for writes)
- rsp_chip_ready  out  1  captured ready field (0 for writes)
- rsp_addr_ok  out  1  captured addr field == request addr (1 for writes)
- scan_phi  out  1  scan phase-1 clock
- scan_phi_bar  out  1  scan phase-2 clock
- scan_data_in  out  1  serial data to chain
- scan_load_chip  out  1  chain-to-chip load strobe
- scan_load_chain  out  1  chip-to-chain capture strobe
- scan_data_out  in  1  serial data from chain
- scan_id  out  1  transaction toggle, seen by chip

Behaviour:
- Reset (async): every output is 0, scan_id=0, FSM=IDLE, shift registers cleared. A reset mid-transaction abandons it with no response.
- req_ready = (state==IDLE) && !rsp_valid.
- On accept, latch the request and build the chain word:
  - bit0 = wen = req_write; bit1 = ren = !req_write.
  - [ADDR_W+1:2] = addr; next DATA_W bits = wdata (reads: wdata=0).
  - next DATA_W bits = rdata = 0; MSB = ready = 0.
- Bit period = 4 steps of PHASE_CYC cycles: PHI_HI (phi=1), GAP_A, PHIB_HI (phi_bar=1), GAP_B.
  - At PHI_HI entry: scan_data_in = word[0], and capture = {scan_data_out, capture[CHAIN_LEN-1:1]}.
  - At GAP_B end: word >>= 1.
- scan_phi and scan_phi_bar are never high together; each is registered and glitch-free.
- FSM sequence:
  - IDLE -> SHIFT_IN: CHAIN_LEN bits.
  - LOAD_CHIP: load_chip=1 for 1 step, then 3 low steps.
  - ID_WAIT: ID_WAIT_CYC cycles, then scan_id toggles.
  - Write -> RESP.
  - Read -> SETTLE (SETTLE_CYC) -> LOAD_CHAIN -> SHIFT_OUT -> RESP.
- LOAD_CHAIN, in steps: load_chain=1; phi pulse; gap; phi_bar pulse; gap; load_chain=0; then 4 idle steps.
- SHIFT_OUT: CHAIN_LEN bits with scan_data_in=0. Capture is taken exactly as in SHIFT_IN.
- RESP: rsp_valid=1 with fields decoded from the capture. It clears on rsp_ack, then the FSM returns to IDLE.
- Back-to-back requests: the next one is accepted the cycle after rsp_ack.
- Write latency (accept to rsp_valid): 4*PHASE_CYC*CHAIN_LEN + 4*PHASE_CYC + ID_WAIT_CYC + 1 cycles, exact; the bench checks this.
- Read latency = write latency + SETTLE_CYC + 10*PHASE_CYC + 4*PHASE_CYC*CHAIN_LEN.
- Counters are sized by $clog2 of their maximum count, with no wrap inside a transaction.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Package scan_pkg holds:
  - the FSM state enum;
  - a chain-length function of (ADDR_W, DATA_W);
  - field offset functions (WEN_BIT, REN_BIT, ADDR_LSB, WDATA_LSB, RDATA_LSB, READY_BIT).
- Sub-module scan_phase_gen: PHASE_CYC divider emitting a 1-cycle step tick plus a 2-bit step index.
  - It is enabled by the FSM and restarts on enable rise.

Test Plan:
- Reset, then idle 100 cycles -> all scan outputs 0, req_ready=1, rsp_valid=0. Assert rst_n low mid-SHIFT_IN -> outputs 0 same cycle, no response afterwards.
- Write addr=0x00001, wdata=0x87654321 (PHASE_CYC=2), to a behavioural 87-bit chain model -> model latches wen=1, ren=0, addr=0x00001, wdata=0x87654321 on load_chip. scan_id toggles exactly once; rsp_valid arrives at the exact write latency with rsp_addr_ok=1.
- Three writes to 0x00800 with wdata 0x02000000, 0x04000000, 0x08000000 -> scan_id toggles 3 times; phi/phi_bar overlap never occurs (assertion).
- Read 0x00800, model returns rdata=0xDEADBEEF, ready=1 -> rsp_is_read=1, rsp_rdata=0xDEADBEEF, rsp_chip_ready=1, rsp_addr_ok=1.
- Read where the model corrupts the addr field to 0x00801 -> rsp_addr_ok=0, rsp_rdata still reported.
- Hold rsp_ack=0 for 50 cycles with req_valid=1 -> rsp_valid held, req_ready=0, no scan activity. Second request accepted the cycle after rsp_ack.
